// File: rtl/mac_array_seq.sv
// rtl/mac_array_seq.sv - WS/OS MAC array pass sequencer; optional stall counter under SEQ_STALL_CNT_EN
module mac_array_seq #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int k_size   = 9,
    parameter int input_ch = 3,
    parameter int bw_cnt   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic       l0_empty,
    input  logic       ififo_empty,
    input  logic       ofifo_full,
    input  logic       os_valid,
    output logic       toggle,
    output logic [1:0] inst_w,
    output logic       l0_rd,
    output logic       ififo_rd,
    output logic       ofifo_wr,
    output logic       busy,
    output logic       done
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRAIN, DONE} state_t;

    // Terminal counts: the counter value on the last beat of each phase.
    localparam logic [bw_cnt-1:0] LOAD_LAST    = bw_cnt'(row - 1);
    localparam logic [bw_cnt-1:0] WS_EXEC_LAST = bw_cnt'(k_size - 1);
    localparam logic [bw_cnt-1:0] OS_EXEC_LAST = bw_cnt'(k_size * input_ch - 1);
    localparam logic [bw_cnt-1:0] SKEW_LAST    = bw_cnt'(row + col - 2);
    localparam logic [bw_cnt-1:0] COL_LAST     = bw_cnt'(col - 1);

    state_t            state_q, state_d;
    logic [bw_cnt-1:0] cnt_q, cnt_d;
    // DRAIN has two sub-phases: waiting (skew or os_valid) then writing out.
    logic              wr_phase_q, wr_phase_d;
    logic              toggle_q, toggle_d;
    logic [1:0]        inst_w_q, inst_w_d;
    logic              l0_rd_q, l0_rd_d;
    logic              ififo_rd_q, ififo_rd_d;
    logic              ofifo_wr_q, ofifo_wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              beat_ok;

    // Next-state, counter and next-cycle output decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_phase_d = wr_phase_q;
        toggle_d   = toggle_q;
        inst_w_d   = 2'b00;
        l0_rd_d    = 1'b0;
        ififo_rd_d = 1'b0;
        ofifo_wr_d = 1'b0;
        done_d     = 1'b0;
        beat_ok    = 1'b0;
        case (state_q)
            IDLE: begin
                // busy_q is still high the cycle the done pulse is shown; drop starts then too.
                if (start && !busy_q) begin
                    toggle_d   = mode;
                    cnt_d      = '0;
                    wr_phase_d = 1'b0;
                    state_d    = mode ? EXEC : LOAD;
                end
            end
            LOAD: begin
                if (!l0_empty) begin
                    inst_w_d = 2'b01;
                    l0_rd_d  = 1'b1;
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EXEC: begin
                beat_ok = !l0_empty && (!toggle_q || !ififo_empty);
                if (beat_ok) begin
                    inst_w_d   = 2'b10;
                    l0_rd_d    = 1'b1;
                    ififo_rd_d = toggle_q;
                    if (cnt_q == (toggle_q ? OS_EXEC_LAST : WS_EXEC_LAST)) begin
                        cnt_d      = '0;
                        wr_phase_d = 1'b0;
                        state_d    = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!wr_phase_q) begin
                    if (toggle_q) begin
                        if (os_valid) begin
                            wr_phase_d = 1'b1;
                        end
                    end else if (cnt_q == SKEW_LAST) begin
                        cnt_d      = '0;
                        wr_phase_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!ofifo_full) begin
                    ofifo_wr_d = 1'b1;
                    if (cnt_q == COL_LAST) begin
                        cnt_d      = '0;
                        wr_phase_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // Busy covers the done pulse cycle so the pass reads as one contiguous window.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    // State and registered outputs; reset abandons any pass in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_phase_q <= 1'b0;
            toggle_q   <= 1'b0;
            inst_w_q   <= 2'b00;
            l0_rd_q    <= 1'b0;
            ififo_rd_q <= 1'b0;
            ofifo_wr_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_phase_q <= wr_phase_d;
            toggle_q   <= toggle_d;
            inst_w_q   <= inst_w_d;
            l0_rd_q    <= l0_rd_d;
            ififo_rd_q <= ififo_rd_d;
            ofifo_wr_q <= ofifo_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign toggle   = toggle_q;
    assign inst_w   = inst_w_q;
    assign l0_rd    = l0_rd_q;
    assign ififo_rd = ififo_rd_q;
    assign ofifo_wr = ofifo_wr_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef SEQ_STALL_CNT_EN
    logic        stall_w;
    logic        accept_w;
    logic [15:0] stall_cnt_q;

    // A stall is a cycle whose required source is empty or whose output sink is full.
    assign stall_w = ((state_q == LOAD) && l0_empty) ||
                     ((state_q == EXEC) && (l0_empty || (toggle_q && ififo_empty))) ||
                     ((state_q == DRAIN) && wr_phase_q && ofifo_full);
    assign accept_w = (state_q == IDLE) && start && !busy_q;

    // Saturating stall counter, restarted by each accepted pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (accept_w) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_array_seq.sv
// tb/tb_mac_array_seq.sv - self-checking bench for mac_array_seq against a phase-list reference model
module tb_mac_array_seq;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int KS   = 9;
    localparam int IC   = 3;
    localparam int MAXC = 320;

    localparam int K_LOAD = 0;
    localparam int K_EXEC = 1;
    localparam int K_SKEW = 2;
    localparam int K_WAIT = 3;
    localparam int K_WR   = 4;
    localparam int K_DONE = 5;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic       l0_empty;
    logic       ififo_empty;
    logic       ofifo_full;
    logic       os_valid;
    logic       toggle;
    logic [1:0] inst_w;
    logic       l0_rd;
    logic       ififo_rd;
    logic       ofifo_wr;
    logic       busy;
    logic       done;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    mac_array_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .l0_empty    (l0_empty),
        .ififo_empty (ififo_empty),
        .ofifo_full  (ofifo_full),
        .os_valid    (os_valid),
        .toggle      (toggle),
        .inst_w      (inst_w),
        .l0_rd       (l0_rd),
        .ififo_rd    (ififo_rd),
        .ofifo_wr    (ofifo_wr),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-cycle stimulus for the cycle in which it is applied (cycle 0 carries the start).
    bit sv_start [MAXC];
    bit sv_mode  [MAXC];
    bit sv_l0e   [MAXC];
    bit sv_ife   [MAXC];
    bit sv_full  [MAXC];
    bit sv_osv   [MAXC];

    // Output vector {toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done} per cycle.
    logic [7:0] exp_v [MAXC];
    logic [7:0] obs_v [MAXC];
    bit         model_toggle;
    int         exp_end;
    int         exp_stalls;

    task automatic fill_stim(input bit m);
        for (int t = 0; t < MAXC; t++) begin
            sv_start[t] = 1'b0;
            sv_mode[t]  = m;
            sv_l0e[t]   = 1'b0;
            sv_ife[t]   = 1'b0;
            sv_full[t]  = 1'b0;
            sv_osv[t]   = 1'b0;
        end
        sv_start[0] = 1'b1;
    endtask

    // Reference: a pass is a list of phases, each needing a number of productive cycles.
    task automatic model_pass();
        int  kinds[$];
        int  lens[$];
        int  p;
        int  n;
        bit  m;
        bit  fin;
        logic [1:0] iw;
        bit  l0r, ifr, wr, dn;
        m = sv_mode[0];
        if (!m) begin
            kinds.push_back(K_LOAD); lens.push_back(ROW);
            kinds.push_back(K_EXEC); lens.push_back(KS);
            kinds.push_back(K_SKEW); lens.push_back(ROW + COL - 1);
        end else begin
            kinds.push_back(K_EXEC); lens.push_back(KS * IC);
            kinds.push_back(K_WAIT); lens.push_back(1);
        end
        kinds.push_back(K_WR);   lens.push_back(COL);
        kinds.push_back(K_DONE); lens.push_back(1);
        exp_v[0]   = {model_toggle, 7'b0};
        exp_v[1]   = {m, 2'b00, 3'b000, 1'b1, 1'b0};
        p          = 0;
        n          = 0;
        fin        = 1'b0;
        exp_stalls = 0;
        exp_end    = MAXC - 1;
        for (int t = 1; t < MAXC - 1; t++) begin
            iw = 2'b00; l0r = 0; ifr = 0; wr = 0; dn = 0;
            if (fin) begin
                exp_v[t+1] = {m, 7'b0};
                continue;
            end
            case (kinds[p])
                K_LOAD: if (!sv_l0e[t]) begin iw = 2'b01; l0r = 1; n++; end else exp_stalls++;
                K_EXEC: if (!sv_l0e[t] && (!m || !sv_ife[t])) begin
                            iw = 2'b10; l0r = 1; ifr = m; n++;
                        end else exp_stalls++;
                K_SKEW: n++;
                K_WAIT: if (sv_osv[t]) n++;
                K_WR:   if (!sv_full[t]) begin wr = 1; n++; end else exp_stalls++;
                default: begin dn = 1; n++; end
            endcase
            exp_v[t+1] = {m, iw, l0r, ifr, wr, 1'b1, dn};
            if (n == lens[p]) begin
                if (kinds[p] == K_DONE) begin
                    fin     = 1'b1;
                    exp_end = t + 1;
                end
                p++;
                n = 0;
            end
        end
        model_toggle = m;
    endtask

    task automatic run_dut(input int ncyc);
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            obs_v[t]    = {toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done};
            start       = sv_start[t];
            mode        = sv_mode[t];
            l0_empty    = sv_l0e[t];
            ififo_empty = sv_ife[t];
            ofifo_full  = sv_full[t];
            os_valid    = sv_osv[t];
        end
        @(negedge clk);
        start = 0; l0_empty = 0; ififo_empty = 0; ofifo_full = 0; os_valid = 0;
    endtask

    function automatic int pass_len();
        return (exp_end + 3 > MAXC) ? MAXC : exp_end + 3;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        start = 0; mode = 0; l0_empty = 0; ififo_empty = 0; ofifo_full = 0; os_valid = 0;
        model_toggle = 1'b0;
        #2;
        n_cmp++;
        if ({toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async got %b want 00000000", {toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done});
        end
        repeat (3) @(negedge clk);
        start = 1; mode = 1;
        @(negedge clk);
        n_cmp++;
        if ({toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held got %b want 00000000", {toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done});
        end
        start = 0; mode = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release_idle got %b want 00000000", {toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done});
        end
    endtask

    task automatic test_ws_nominal();
        int n, c01, c10, cwr, dcyc, last_ex, first_wr;
        fill_stim(1'b0);
        model_pass();
        n = pass_len();
        run_dut(n);
        c01 = 0; c10 = 0; cwr = 0; dcyc = -1; last_ex = -1; first_wr = -1;
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs_v[t] !== exp_v[t]) begin
                n_fail++;
                $display("FAIL ws_trace t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
            end
            if (obs_v[t][6:5] == 2'b01) c01++;
            if (obs_v[t][6:5] == 2'b10) begin c10++; last_ex = t; end
            if (obs_v[t][2]) begin cwr++; if (first_wr < 0) first_wr = t; end
            if (obs_v[t][0]) dcyc = t;
        end
        n_cmp++; if (c01 !== 8)  begin n_fail++; $display("FAIL ws_load_beats got %0d want 8", c01); end
        n_cmp++; if (c10 !== 9)  begin n_fail++; $display("FAIL ws_exec_beats got %0d want 9", c10); end
        n_cmp++; if ((first_wr - last_ex - 1) !== 15) begin
            n_fail++; $display("FAIL ws_skew_gap got %0d want 15", first_wr - last_ex - 1);
        end
        n_cmp++; if (cwr !== 8)  begin n_fail++; $display("FAIL ws_writes got %0d want 8", cwr); end
        n_cmp++; if (dcyc !== 42) begin n_fail++; $display("FAIL ws_done_cycle got %0d want 42", dcyc); end
    endtask

    task automatic test_os_nominal();
        int n, cex, cwr, cdn, dcyc;
        fill_stim(1'b1);
        for (int t = 30; t < MAXC; t++) sv_osv[t] = 1'b1;
        model_pass();
        n = pass_len();
        run_dut(n);
        cex = 0; cwr = 0; cdn = 0; dcyc = -1;
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs_v[t] !== exp_v[t]) begin
                n_fail++;
                $display("FAIL os_trace t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
            end
            if (obs_v[t][6:5] == 2'b10 && obs_v[t][3]) cex++;
            if (obs_v[t][2]) cwr++;
            if (obs_v[t][0]) begin cdn++; dcyc = t; end
        end
        n_cmp++; if (cex !== 27) begin n_fail++; $display("FAIL os_exec_beats got %0d want 27", cex); end
        n_cmp++; if (cwr !== 8)  begin n_fail++; $display("FAIL os_writes got %0d want 8", cwr); end
        n_cmp++; if (cdn !== 1)  begin n_fail++; $display("FAIL os_done_pulses got %0d want 1", cdn); end
        n_cmp++; if (dcyc !== 40) begin n_fail++; $display("FAIL os_done_cycle got %0d want 40", dcyc); end
    endtask

    task automatic test_os_ififo_stall();
        int n, cex, cidle, dcyc;
        fill_stim(1'b1);
        for (int t = 10; t < 14; t++) sv_ife[t] = 1'b1;
        for (int t = 34; t < MAXC; t++) sv_osv[t] = 1'b1;
        model_pass();
        n = pass_len();
        run_dut(n);
        cex = 0; cidle = 0; dcyc = -1;
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs_v[t] !== exp_v[t]) begin
                n_fail++;
                $display("FAIL os_stall_trace t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
            end
            if (obs_v[t][6:5] == 2'b10) cex++;
            if (t >= 11 && t <= 14 && obs_v[t][6:3] == 4'b0000) cidle++;
            if (obs_v[t][0]) dcyc = t;
        end
        n_cmp++; if (cidle !== 4) begin n_fail++; $display("FAIL os_stall_idle got %0d want 4", cidle); end
        n_cmp++; if (cex !== 27)  begin n_fail++; $display("FAIL os_stall_beats got %0d want 27", cex); end
        n_cmp++; if (dcyc !== 44) begin n_fail++; $display("FAIL os_stall_done_cycle got %0d want 44", dcyc); end
    endtask

    task automatic test_ofifo_full();
        int n, cwr, dcyc;
        fill_stim(1'b0);
        for (int t = 35; t < 38; t++) sv_full[t] = 1'b1;
        model_pass();
        n = pass_len();
        run_dut(n);
        cwr = 0; dcyc = -1;
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs_v[t] !== exp_v[t]) begin
                n_fail++;
                $display("FAIL full_trace t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
            end
            if (obs_v[t][2]) cwr++;
            if (obs_v[t][0]) dcyc = t;
        end
        n_cmp++; if (cwr !== 8)   begin n_fail++; $display("FAIL full_writes got %0d want 8", cwr); end
        n_cmp++; if (dcyc !== 45) begin n_fail++; $display("FAIL full_done_cycle got %0d want 45", dcyc); end
`ifdef SEQ_STALL_CNT_EN
        n_cmp++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL full_stall_cnt got %0d want 3", stall_cnt); end
`endif
    endtask

    task automatic test_start_ignored();
        int n;
        fill_stim(1'b0);
        sv_start[12] = 1'b1;
        for (int t = 1; t < MAXC; t++) sv_mode[t] = 1'b1;
        model_pass();
        n = pass_len();
        run_dut(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs_v[t] !== exp_v[t]) begin
                n_fail++;
                $display("FAIL ignore_trace t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
        n_cmp++; if (obs_v[14][7] !== 1'b0) begin n_fail++; $display("FAIL ignore_toggle got %b want 0", obs_v[14][7]); end
        n_cmp++; if (obs_v[14][1] !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got %b want 1", obs_v[14][1]); end
    endtask

    task automatic test_async_reset();
        int n, cdn;
        fill_stim(1'b1);
        model_pass();
        run_dut(12);
        n_cmp++;
        if (obs_v[11] !== exp_v[11]) begin
            n_fail++; $display("FAIL areset_pre got %b want %b", obs_v[11], exp_v[11]);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done} !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_outputs got %b want 00000000", {toggle, inst_w, l0_rd, ififo_rd, ofifo_wr, busy, done});
        end
        model_toggle = 1'b0;
        cdn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) cdn++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) cdn++;
        end
        n_cmp++; if (cdn !== 0) begin n_fail++; $display("FAIL areset_no_done got %0d want 0", cdn); end
        fill_stim(1'b0);
        model_pass();
        n = pass_len();
        run_dut(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs_v[t] !== exp_v[t]) begin
                n_fail++;
                $display("FAIL areset_next_trace t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_random();
        int n, cdn;
        bit m;
        for (int pass = 0; pass < 6; pass++) begin
            m = 1'($urandom % 2);
            fill_stim(m);
            for (int t = 1; t < MAXC; t++) begin
                sv_mode[t] = 1'($urandom % 2);
                sv_l0e[t]  = ($urandom % 4) == 0;
                sv_ife[t]  = ($urandom % 4) == 0;
                sv_full[t] = ($urandom % 4) == 0;
                sv_osv[t]  = ($urandom % 3) == 0;
                if (t <= 20) sv_start[t] = ($urandom % 10) == 0;
            end
            model_pass();
            n = pass_len();
            run_dut(n);
            cdn = 0;
            for (int t = 0; t < n; t++) begin
                n_cmp++;
                if (obs_v[t] !== exp_v[t]) begin
                    n_fail++;
                    $display("FAIL rand%0d_trace t=%0d got %b want %b", pass, t, obs_v[t], exp_v[t]);
                end
                if (obs_v[t][0]) cdn++;
            end
            n_cmp++;
            if (cdn !== 1) begin n_fail++; $display("FAIL rand%0d_done_pulses got %0d want 1", pass, cdn); end
`ifdef SEQ_STALL_CNT_EN
            n_cmp++;
            if (stall_cnt !== 16'(exp_stalls)) begin
                n_fail++; $display("FAIL rand%0d_stall_cnt got %0d want %0d", pass, stall_cnt, exp_stalls);
            end
`endif
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ws_nominal();
        test_os_nominal();
        test_os_ififo_stall();
        test_ofifo_full();
        test_start_ignored();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
